// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch unit and its PC target calculator.
package cpu_pkg;

   // Control-transfer codes produced by the decoder
   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_JUMP = 2'b01,
      BR_BEQ  = 2'b10,
      BR_BNE  = 2'b11
   } br_type_e;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_EXEC  = 2'b10
   } fetch_state_e;

   // Byte distance between consecutive instructions
   localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and memory/cache (slave).
// Handshake: the fetch unit holds PC and IMEM_READ steady while IMEM_BUSYWAIT
// is high; IMEM_INSTR is taken on the first rising edge of a read cycle with
// IMEM_BUSYWAIT low. IMEM_INSTR is meaningless whenever IMEM_BUSYWAIT is high.
interface fetch_unit_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
) ();
   logic [PC_W-1:0]    PC;
   logic               IMEM_READ;
   logic               IMEM_BUSYWAIT;
   logic [INSTR_W-1:0] IMEM_INSTR;

   modport master (
      output PC,
      output IMEM_READ,
      input  IMEM_BUSYWAIT,
      input  IMEM_INSTR
   );

   modport slave (
      input  PC,
      input  IMEM_READ,
      output IMEM_BUSYWAIT,
      output IMEM_INSTR
   );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection: sequential step or PC-relative redirect.
module pc_target_calc
   import cpu_pkg::*;
#(
   parameter int PC_W     = 32,
   parameter int OFFSET_W = 8
) (
   input  logic [PC_W-1:0]     pc_i,
   input  logic [1:0]          br_type_i,
   input  logic                zero_i,
   input  logic [OFFSET_W-1:0] br_offset_i,
   output logic [PC_W-1:0]     next_pc_o
);

   logic [PC_W-1:0] seq_pc;
   logic [PC_W-1:0] offset_sext;
   logic [PC_W-1:0] target_pc;

   // Word offset is relative to the sequential PC; all sums wrap silently
   always_comb begin
      seq_pc      = pc_i + PC_W'(PC_STEP);
      offset_sext = {{(PC_W-OFFSET_W){br_offset_i[OFFSET_W-1]}}, br_offset_i};
      target_pc   = seq_pc + (offset_sext << 2);
   end

   // Pick redirect target when the branch condition holds
   always_comb begin
      next_pc_o = seq_pc;
      case (br_type_e'(br_type_i))
         BR_JUMP: next_pc_o = target_pc;
         BR_BEQ:  if (zero_i)  next_pc_o = target_pc;
         BR_BNE:  if (!zero_i) next_pc_o = target_pc;
         default: next_pc_o = seq_pc;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Handshaked instruction fetch and PC control with retired-instruction count.
// One instruction is in flight at a time: IDLE -> FETCH -> EXEC -> FETCH ...
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int PC_W     = 32,
   parameter int INSTR_W  = 32,
   parameter int OFFSET_W = 8,
   parameter int CNT_W    = 16
) (
   input  logic                CLK,
   input  logic                RESET,
   fetch_unit_if.master        imem,
   output logic [INSTR_W-1:0]  INSTR,
   output logic                INSTR_VALID,
   input  logic                STALL,
   input  logic [1:0]          BR_TYPE,
   input  logic                ZERO,
   input  logic [OFFSET_W-1:0] BR_OFFSET,
   output logic [CNT_W-1:0]    RETIRED,
   output fetch_state_e        STATE
);

   fetch_state_e       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               read_q, read_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic [PC_W-1:0]    next_pc;

   pc_target_calc #(
      .PC_W     (PC_W),
      .OFFSET_W (OFFSET_W)
   ) u_pc_target_calc (
      .pc_i        (pc_q),
      .br_type_i   (BR_TYPE),
      .zero_i      (ZERO),
      .br_offset_i (BR_OFFSET),
      .next_pc_o   (next_pc)
   );

   // Next-state and registered-output logic; everything holds unless a state advances
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      read_d    = read_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      retired_d = retired_q;
      case (state_q)
         ST_IDLE: begin
            read_d  = 1'b1;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (!imem.IMEM_BUSYWAIT) begin
               instr_d = imem.IMEM_INSTR;
               valid_d = 1'b1;
               read_d  = 1'b0;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!STALL) begin
               pc_d      = next_pc;
               valid_d   = 1'b0;
               read_d    = 1'b1;
               retired_d = retired_q + 1'b1;
               state_d   = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset wins over every other condition on the same edge
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         read_q    <= 1'b0;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         read_q    <= read_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         retired_q <= retired_d;
      end
   end

   assign imem.PC        = pc_q;
   assign imem.IMEM_READ = read_q;
   assign INSTR          = instr_q;
   assign INSTR_VALID    = valid_q;
   assign RETIRED        = retired_q;
   assign STATE          = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, busywait, branches, wrap, stall, reset.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int PC_W     = 32;
  localparam int INSTR_W  = 32;
  localparam int OFFSET_W = 8;
  localparam int CNT_W    = 16;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  // ---------------- DUT ----------------
  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem ();

  logic [INSTR_W-1:0]  INSTR;
  logic                INSTR_VALID;
  logic                STALL = 1'b0;
  logic [1:0]          BR_TYPE = 2'b00;
  logic                ZERO = 1'b0;
  logic [OFFSET_W-1:0] BR_OFFSET = '0;
  logic [CNT_W-1:0]    RETIRED;
  fetch_state_e        STATE;
  logic                busy = 1'b0;

  fetch_unit #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .imem        (imem.master),
    .INSTR       (INSTR),
    .INSTR_VALID (INSTR_VALID),
    .STALL       (STALL),
    .BR_TYPE     (BR_TYPE),
    .ZERO        (ZERO),
    .BR_OFFSET   (BR_OFFSET),
    .RETIRED     (RETIRED),
    .STATE       (STATE)
  );

  // Memory model: word content is a fixed tag plus the low address bits
  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  assign imem.IMEM_BUSYWAIT = busy;
  assign imem.IMEM_INSTR    = busy ? 32'hDEAD_BEEF : mem_word(imem.PC);

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start in EXEC at some PC; apply redirect inputs, step once, check landing PC
  task automatic exec_step(input string tag, input logic [1:0] br, input logic z,
                           input logic [7:0] off, input logic [31:0] exp_pc);
    BR_TYPE = br; ZERO = z; BR_OFFSET = off;
    tick();
    exp_ret = exp_ret + 1'b1;
    check_val({tag, ".pc"}, 64'(imem.PC), 64'(exp_pc));
    check_val({tag, ".valid"}, 64'(INSTR_VALID), 64'd0);
    check_val({tag, ".read"}, 64'(imem.IMEM_READ), 64'd1);
    check_val({tag, ".ret"}, 64'(RETIRED), 64'(exp_ret));
    BR_TYPE = 2'b00; ZERO = 1'b0; BR_OFFSET = '0;
    tick();
    check_val({tag, ".instr"}, 64'(INSTR), 64'(mem_word(exp_pc)));
    check_val({tag, ".state"}, 64'(STATE), 64'(ST_EXEC));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    RESET = 1'b1;
    tick(); tick();
    check_val("rst.pc", 64'(imem.PC), 64'd0);
    check_val("rst.read", 64'(imem.IMEM_READ), 64'd0);
    check_val("rst.instr", 64'(INSTR), 64'd0);
    check_val("rst.valid", 64'(INSTR_VALID), 64'd0);
    check_val("rst.ret", 64'(RETIRED), 64'd0);
    check_val("rst.state", 64'(STATE), 64'(ST_IDLE));

    // Sequential zero-wait fetch: 0, 4, 8
    RESET = 1'b0;
    tick();
    check_val("idle2fetch.read", 64'(imem.IMEM_READ), 64'd1);
    check_val("idle2fetch.pc", 64'(imem.PC), 64'd0);
    check_val("idle2fetch.state", 64'(STATE), 64'(ST_FETCH));
    tick();
    check_val("exec0.valid", 64'(INSTR_VALID), 64'd1);
    check_val("exec0.instr", 64'(INSTR), 64'hA500_0000);
    check_val("exec0.read", 64'(imem.IMEM_READ), 64'd0);
    exec_step("seq0", 2'b00, 1'b0, 8'h00, 32'd4);
    BR_TYPE = 2'b00;
    tick();
    exp_ret = exp_ret + 1'b1;
    check_val("seq4.pc", 64'(imem.PC), 64'd8);
    check_val("seq4.ret", 64'(RETIRED), 64'd2);

    // Busywait three cycles in FETCH at PC 8
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("bw.pc", 64'(imem.PC), 64'd8);
      check_val("bw.valid", 64'(INSTR_VALID), 64'd0);
      check_val("bw.read", 64'(imem.IMEM_READ), 64'd1);
    end
    busy = 1'b0;
    tick();
    check_val("bw.instr", 64'(INSTR), 64'hA500_0008);
    check_val("bw.validup", 64'(INSTR_VALID), 64'd1);
    exec_step("seq8", 2'b00, 1'b0, 8'h00, 32'd12);
    check_val("seq8.ret3", 64'(RETIRED), 64'd3);

    // Downstream stall two cycles in EXEC at PC 12
    STALL = 1'b1;
    BR_TYPE = 2'b01; BR_OFFSET = 8'h10;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("stall.pc", 64'(imem.PC), 64'd12);
      check_val("stall.valid", 64'(INSTR_VALID), 64'd1);
      check_val("stall.instr", 64'(INSTR), 64'hA500_000C);
      check_val("stall.ret", 64'(RETIRED), 64'd3);
    end
    STALL = 1'b0;
    exec_step("stall_rel", 2'b00, 1'b0, 8'h00, 32'd16);
    check_val("stall_rel.ret4", 64'(RETIRED), 64'd4);

    // Fresh start for the branch sequence
    RESET = 1'b1;
    tick();
    exp_ret = '0;
    check_val("rst2.ret", 64'(RETIRED), 64'd0);
    RESET = 1'b0;
    tick(); tick();
    check_val("rst2.state", 64'(STATE), 64'(ST_EXEC));
    exec_step("b_seq0",   2'b00, 1'b0, 8'h00, 32'd4);
    exec_step("beq_tk",   2'b10, 1'b1, 8'hFE, 32'd0);
    exec_step("b_seq0b",  2'b00, 1'b0, 8'h00, 32'd4);
    exec_step("beq_nt",   2'b10, 1'b0, 8'hFE, 32'd8);
    exec_step("jmp_back", 2'b01, 1'b0, 8'hFD, 32'd0);
    exec_step("b_seq0c",  2'b00, 1'b0, 8'h00, 32'd4);
    exec_step("bne_tk",   2'b11, 1'b0, 8'h02, 32'd16);
    exec_step("bne_nt",   2'b11, 1'b1, 8'h02, 32'd20);
    exec_step("jmp_neg",  2'b01, 1'b0, 8'hF9, 32'hFFFF_FFFC);
    exec_step("jmp_wrap", 2'b01, 1'b0, 8'h00, 32'd0);
    exec_step("jmp_max",  2'b01, 1'b1, 8'h7F, 32'h0000_0200);
    check_val("br.ret", 64'(RETIRED), 64'd11);

    // Reset mid-FETCH while memory is busy; late data must not be captured
    BR_TYPE = 2'b01; BR_OFFSET = 8'h40;
    tick();
    exp_ret = exp_ret + 1'b1;
    check_val("pre_rst.state", 64'(STATE), 64'(ST_FETCH));
    busy = 1'b1;
    tick();
    check_val("pre_rst.pc", 64'(imem.PC), 64'h0000_0304);
    RESET = 1'b1;
    tick();
    check_val("midrst.pc", 64'(imem.PC), 64'd0);
    check_val("midrst.read", 64'(imem.IMEM_READ), 64'd0);
    check_val("midrst.valid", 64'(INSTR_VALID), 64'd0);
    check_val("midrst.ret", 64'(RETIRED), 64'd0);
    check_val("midrst.instr", 64'(INSTR), 64'd0);
    RESET = 1'b0;
    busy = 1'b0;
    BR_TYPE = 2'b00; BR_OFFSET = '0;
    tick();
    check_val("post_rst.state", 64'(STATE), 64'(ST_FETCH));
    check_val("post_rst.instr", 64'(INSTR), 64'd0);
    check_val("post_rst.valid", 64'(INSTR_VALID), 64'd0);
    tick();
    check_val("post_rst.exec", 64'(INSTR), 64'hA500_0000);
    check_val("post_rst.pc", 64'(imem.PC), 64'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
